// File: rtl/sram_bank_pkg.sv
// rtl/sram_bank_pkg.sv - shared types and helpers for the SRAM bank array
// Purpose: init FSM state type, parity helper and error-counter width used by
//          sram_bank_array and sram_bank_core.
package sram_bank_pkg;

   typedef enum logic {
      INIT  = 1'b0,
      READY = 1'b1
   } init_state_t;

   localparam int PARITY_ERR_CNT_WIDTH = 16;

   // Even parity: the stored bit makes the byte plus parity an even count of ones.
   function automatic logic byte_parity(input logic [7:0] b);
      return ^b;
   endfunction

endpackage

// File: rtl/sram_bank_core.sv
// rtl/sram_bank_core.sv - one single-port SRAM bank with byte enables and a fixed-latency read pipe
// Purpose: storage array, byte-enable write, LAT-stage read pipeline with valid bits,
//          optional per-byte even parity (macro SRAM_BANK_ARRAY_PARITY_EN).
// Ports:
//   clk_i, rst_ni    clock, synchronous active-low reset (clears pipe valids and outputs only)
//   wr_en, rd_en     write / read strobes, already qualified by the top
//   rd_zero          read returns 0 instead of storage (out-of-range address)
//   addr, be, wdata  word index, byte enables, write data
//   inject_parity    invert stored byte-0 parity on this write
//   rdata            read data, updates LAT cycles after a sampled read, then holds
//   parity_err       one-cycle pulse aligned with a failing rdata
//   parity_fail      combinational pre-register view of parity_err, for the top's counter
module sram_bank_core
   import sram_bank_pkg::*;
#(
   parameter int DW    = 32,
   parameter int DEPTH = 1024,
   parameter int LAT   = 2,
   parameter int IDX_W = 10
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             wr_en,
   input  logic             rd_en,
   input  logic             rd_zero,
   input  logic [IDX_W-1:0] addr,
   input  logic [DW/8-1:0]  be,
   input  logic [DW-1:0]    wdata,
   input  logic             inject_parity,
   output logic [DW-1:0]    rdata,
   output logic             parity_err,
   output logic             parity_fail
);

   localparam int NB = DW / 8;

   logic [DW-1:0]  mem [DEPTH];
   logic [DW-1:0]  rd_word;
   logic [DW-1:0]  pipe_data [LAT];
   logic [LAT-1:0] pipe_vld;

   // Storage has no reset; writes are blocked while reset is held.
   always_ff @(posedge clk_i) begin
      if (rst_ni && wr_en) begin
         for (int b = 0; b < NB; b++) begin
            if (be[b]) begin
               mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
         end
      end
   end

   assign rd_word = rd_zero ? '0 : mem[addr];

   always_ff @(posedge clk_i) begin
      pipe_data[0] <= rd_word;
      for (int i = 1; i < LAT; i++) begin
         pipe_data[i] <= pipe_data[i-1];
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         pipe_vld   <= '0;
         rdata      <= '0;
         parity_err <= 1'b0;
      end else begin
         pipe_vld[0] <= rd_en;
         for (int i = 1; i < LAT; i++) begin
            pipe_vld[i] <= pipe_vld[i-1];
         end
         if (pipe_vld[LAT-1]) begin
            rdata <= pipe_data[LAT-1];
         end
         parity_err <= parity_fail;
      end
   end

`ifdef SRAM_BANK_ARRAY_PARITY_EN
   logic [NB-1:0] par_mem [DEPTH];
   logic [NB-1:0] rd_par;
   logic [NB-1:0] pipe_par [LAT];

   always_ff @(posedge clk_i) begin
      if (rst_ni && wr_en) begin
         for (int b = 0; b < NB; b++) begin
            if (be[b]) begin
               par_mem[addr][b] <= byte_parity(wdata[8*b +: 8]) ^ (inject_parity && (b == 0));
            end
         end
      end
   end

   // Zero data carries zero parity, so out-of-range reads never flag an error.
   assign rd_par = rd_zero ? '0 : par_mem[addr];

   always_ff @(posedge clk_i) begin
      pipe_par[0] <= rd_par;
      for (int i = 1; i < LAT; i++) begin
         pipe_par[i] <= pipe_par[i-1];
      end
   end

   always_comb begin
      parity_fail = 1'b0;
      if (pipe_vld[LAT-1]) begin
         for (int b = 0; b < NB; b++) begin
            if (byte_parity(pipe_data[LAT-1][8*b +: 8]) != pipe_par[LAT-1][b]) begin
               parity_fail = 1'b1;
            end
         end
      end
   end
`else
   logic unused_inject;
   assign unused_inject = inject_parity;
   assign parity_fail   = 1'b0;
`endif

endmodule

// File: rtl/sram_bank_array.sv
// rtl/sram_bank_array.sv - ROWS x COLS single-port SRAM bank array with zero-init sweep
// Purpose: init FSM and sweep counter, address range check, sticky error flags and
//          parity error counter around ROWS*COLS sram_bank_core instances.
//          Optional parity build: define SRAM_BANK_ARRAY_PARITY_EN.
// Ports:
//   clk_i, rst_ni       clock, synchronous active-low reset
//   bank_addr           word address shared by all banks
//   bank_cs/we/be       per-bank select, write (1) / read (0), byte enables
//   bank_wdata          write data per column (rows share it)
//   bank_rdata          read data per bank
//   init_done_o         array ready for accesses
//   oob_err_o           sticky: access with bank_addr >= SRAM_BANK_DEPTH
//   early_access_o      sticky: cs seen before init_done_o
//   parity_err_o        per-bank parity error pulse aligned with bank_rdata
//   parity_err_cnt_o    saturating parity error count
//   inject_parity_i     corrupt byte-0 parity of writes this cycle
module sram_bank_array
   import sram_bank_pkg::*;
#(
   parameter int SRAM_BANKS_ROWS      = 1,
   parameter int SRAM_BANKS_COLS      = 1,
   parameter int SRAM_BANK_ADDR_WIDTH = 16,
   parameter int SRAM_BANK_DATA_WIDTH = 32,
   parameter int SRAM_BANK_DEPTH      = 1024,
   parameter int SRAM_READ_LATENCY    = 2,
   parameter int INIT_ON_RESET        = 1
) (
   input  logic                                                        clk_i,
   input  logic                                                        rst_ni,
   input  logic [SRAM_BANK_ADDR_WIDTH-1:0]                             bank_addr,
   input  logic [SRAM_BANKS_ROWS-1:0][SRAM_BANKS_COLS-1:0]             bank_cs,
   input  logic [SRAM_BANKS_ROWS-1:0][SRAM_BANKS_COLS-1:0]             bank_we,
   input  logic [SRAM_BANKS_ROWS-1:0][SRAM_BANKS_COLS-1:0][SRAM_BANK_DATA_WIDTH/8-1:0] bank_be,
   input  logic [SRAM_BANKS_COLS-1:0][SRAM_BANK_DATA_WIDTH-1:0]        bank_wdata,
   output logic [SRAM_BANKS_ROWS-1:0][SRAM_BANKS_COLS-1:0][SRAM_BANK_DATA_WIDTH-1:0] bank_rdata,
   output logic                                                        init_done_o,
   output logic                                                        oob_err_o,
   output logic                                                        early_access_o,
   output logic [SRAM_BANKS_ROWS-1:0][SRAM_BANKS_COLS-1:0]             parity_err_o,
   output logic [PARITY_ERR_CNT_WIDTH-1:0]                             parity_err_cnt_o,
   input  logic                                                        inject_parity_i
);

   localparam int ROWS  = SRAM_BANKS_ROWS;
   localparam int COLS  = SRAM_BANKS_COLS;
   localparam int AW    = SRAM_BANK_ADDR_WIDTH;
   localparam int DW    = SRAM_BANK_DATA_WIDTH;
   localparam int NB    = DW / 8;
   localparam int DEPTH = SRAM_BANK_DEPTH;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PARITY_ERR_CNT_WIDTH;
   localparam int SUM_W = CNT_W + 1;

   init_state_t state_q, state_d;
   logic [IDX_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] err_cnt_d;

   logic                                 in_range;
   logic                                 ready;
   logic                                 any_cs;
   logic                                 rd_zero;
   logic [IDX_W-1:0]                     core_addr;
   logic                                 core_inject;
   logic [ROWS-1:0][COLS-1:0]            core_we;
   logic [ROWS-1:0][COLS-1:0]            core_re;
   logic [ROWS-1:0][COLS-1:0][NB-1:0]    core_be;
   logic [COLS-1:0][DW-1:0]              core_wdata;
   logic [ROWS-1:0][COLS-1:0]            par_fail;

   // Widen both sides so DEPTH == 2**AW compares correctly.
   assign in_range = ({1'b0, bank_addr} < (AW+1)'(DEPTH));
   assign ready    = (state_q == READY);
   assign any_cs   = |bank_cs;

   // During INIT the sweep owns every bank; user accesses are dropped.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      core_we     = '0;
      core_re     = '0;
      core_be     = '0;
      core_wdata  = '0;
      core_addr   = bank_addr[IDX_W-1:0];
      core_inject = 1'b0;
      rd_zero     = 1'b0;
      case (state_q)
         INIT: begin
            core_we   = '1;
            core_be   = '1;
            core_addr = cnt_q;
            if (cnt_q == IDX_W'(DEPTH - 1)) begin
               state_d = READY;
            end else begin
               cnt_d = cnt_q + IDX_W'(1);
            end
         end
         READY: begin
            core_be     = bank_be;
            core_wdata  = bank_wdata;
            core_inject = inject_parity_i;
            rd_zero     = !in_range;
            for (int r = 0; r < ROWS; r++) begin
               for (int c = 0; c < COLS; c++) begin
                  core_we[r][c] = bank_cs[r][c] & bank_we[r][c] & in_range;
                  core_re[r][c] = bank_cs[r][c] & ~bank_we[r][c];
               end
            end
         end
         default: state_d = INIT;
      endcase
   end

`ifdef SRAM_BANK_ARRAY_PARITY_EN
   logic [SUM_W-1:0] fail_sum;
   logic [SUM_W-1:0] cnt_sum;

   always_comb begin
      fail_sum = '0;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            fail_sum = fail_sum + SUM_W'(par_fail[r][c]);
         end
      end
      cnt_sum   = {1'b0, parity_err_cnt_o} + fail_sum;
      err_cnt_d = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
   end
`else
   logic unused_par_fail;
   assign unused_par_fail = |par_fail;
   assign err_cnt_d       = '0;
`endif

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q          <= (INIT_ON_RESET != 0) ? INIT : READY;
         cnt_q            <= '0;
         init_done_o      <= 1'b0;
         oob_err_o        <= 1'b0;
         early_access_o   <= 1'b0;
         parity_err_cnt_o <= '0;
      end else begin
         state_q          <= state_d;
         cnt_q            <= cnt_d;
         init_done_o      <= (state_d == READY);
         parity_err_cnt_o <= err_cnt_d;
         if (ready && any_cs && !in_range) begin
            oob_err_o <= 1'b1;
         end
         if (!ready && any_cs) begin
            early_access_o <= 1'b1;
         end
      end
   end

   for (genvar r = 0; r < ROWS; r++) begin : g_row
      for (genvar c = 0; c < COLS; c++) begin : g_col
         sram_bank_core #(
            .DW    (DW),
            .DEPTH (DEPTH),
            .LAT   (SRAM_READ_LATENCY),
            .IDX_W (IDX_W)
         ) u_core (
            .clk_i         (clk_i),
            .rst_ni        (rst_ni),
            .wr_en         (core_we[r][c]),
            .rd_en         (core_re[r][c]),
            .rd_zero       (rd_zero),
            .addr          (core_addr),
            .be            (core_be[r][c]),
            .wdata         (core_wdata[c]),
            .inject_parity (core_inject),
            .rdata         (bank_rdata[r][c]),
            .parity_err    (parity_err_o[r][c]),
            .parity_fail   (par_fail[r][c])
         );
      end
   end

endmodule

// File: tb/tb_sram_bank_array.sv
// tb/tb_sram_bank_array.sv - directed self-checking bench for sram_bank_array
module tb_sram_bank_array;

   localparam int ROWS = 1;
   localparam int COLS = 2;
   localparam int AW   = 16;
   localparam int DW   = 32;

   logic                                   clk_i = 1'b0;
   logic                                   rst_ni;
   logic [AW-1:0]                          bank_addr;
   logic [ROWS-1:0][COLS-1:0]              bank_cs;
   logic [ROWS-1:0][COLS-1:0]              bank_we;
   logic [ROWS-1:0][COLS-1:0][DW/8-1:0]    bank_be;
   logic [COLS-1:0][DW-1:0]                bank_wdata;
   logic [ROWS-1:0][COLS-1:0][DW-1:0]      bank_rdata;
   logic                                   init_done_o;
   logic                                   oob_err_o;
   logic                                   early_access_o;
   logic [ROWS-1:0][COLS-1:0]              parity_err_o;
   logic [15:0]                            parity_err_cnt_o;
   logic                                   inject_parity_i;

   int errors = 0;
   int checks = 0;

   sram_bank_array #(
      .SRAM_BANKS_ROWS      (ROWS),
      .SRAM_BANKS_COLS      (COLS),
      .SRAM_BANK_ADDR_WIDTH (AW),
      .SRAM_BANK_DATA_WIDTH (DW),
      .SRAM_BANK_DEPTH      (1024),
      .SRAM_READ_LATENCY    (2),
      .INIT_ON_RESET        (1)
   ) dut (
      .clk_i            (clk_i),
      .rst_ni           (rst_ni),
      .bank_addr        (bank_addr),
      .bank_cs          (bank_cs),
      .bank_we          (bank_we),
      .bank_be          (bank_be),
      .bank_wdata       (bank_wdata),
      .bank_rdata       (bank_rdata),
      .init_done_o      (init_done_o),
      .oob_err_o        (oob_err_o),
      .early_access_o   (early_access_o),
      .parity_err_o     (parity_err_o),
      .parity_err_cnt_o (parity_err_cnt_o),
      .inject_parity_i  (inject_parity_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle();
      bank_cs         = '0;
      bank_we         = '0;
      bank_be         = '0;
      inject_parity_i = 1'b0;
   endtask

   task automatic wr(input int c, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input logic [3:0] be, input logic inj);
      idle();
      bank_cs[0][c]   = 1'b1;
      bank_we[0][c]   = 1'b1;
      bank_be[0][c]   = be;
      bank_addr       = a;
      bank_wdata[c]   = d;
      inject_parity_i = inj;
      tick();
      idle();
   endtask

   // Issue a read and return after the cycle where its data must be visible.
   task automatic rd(input int c, input logic [AW-1:0] a);
      idle();
      bank_cs[0][c] = 1'b1;
      bank_addr     = a;
      tick();
      idle();
      tick();
      tick();
   endtask

   task automatic wait_init(output int n);
      n = 0;
      while (!init_done_o && n < 2000) begin
         tick();
         n++;
      end
   endtask

   initial begin
      int n;
      int bad;
      logic [DW-1:0] exp3 [4];
      logic [1:0]  exp_perr;
      logic [15:0] exp_pcnt;

      exp3[0] = 32'hA000_0000;
      exp3[1] = 32'hA000_0001;
      exp3[2] = 32'hA000_0002;
      exp3[3] = 32'hA000_0003;
`ifdef SRAM_BANK_ARRAY_PARITY_EN
      exp_perr = 2'b01;
      exp_pcnt = 16'd1;
`else
      exp_perr = 2'b00;
      exp_pcnt = 16'd0;
`endif

      rst_ni     = 1'b0;
      bank_addr  = '0;
      bank_wdata = '0;
      idle();
      tick();
      tick();
      chk("rst_rdata", 64'(bank_rdata), 64'd0);
      chk("rst_init_done", 64'(init_done_o), 64'd0);
      chk("rst_oob", 64'(oob_err_o), 64'd0);
      chk("rst_early", 64'(early_access_o), 64'd0);
      chk("rst_perr", 64'(parity_err_o), 64'd0);
      chk("rst_pcnt", 64'(parity_err_cnt_o), 64'd0);

      // Sweep length and all-zero contents.
      rst_ni = 1'b1;
      wait_init(n);
      chk("init_cycles", 64'(n), 64'd1024);
      bad = 0;
      for (int i = 0; i < 1026; i++) begin
         idle();
         if (i < 1024) begin
            bank_cs   = 2'b11;
            bank_addr = AW'(i);
         end
         tick();
         if (i >= 2 && bank_rdata !== '0) bad++;
      end
      idle();
      chk("sweep_all_zero_bad", 64'(bad), 64'd0);
      chk("no_early_after_clean_init", 64'(early_access_o), 64'd0);

      // Byte-enable merge and read latency.
      wr(0, 16'd5, 32'hDEAD_BEEF, 4'b1111, 1'b0);
      wr(0, 16'd5, 32'h00AA_0000, 4'b0100, 1'b0);
      bank_cs[0][0] = 1'b1;
      bank_addr     = 16'd5;
      tick();
      idle();
      tick();
      chk("lat_not_early", 64'(bank_rdata[0][0]), 64'd0);
      tick();
      chk("be_merge", 64'(bank_rdata[0][0]), 64'hDEAA_BEEF);

      // Write then immediate read of the same address.
      wr(0, 16'd6, 32'h1234_5678, 4'b1111, 1'b0);
      rd(0, 16'd6);
      chk("wr_then_rd", 64'(bank_rdata[0][0]), 64'h1234_5678);

      // Pipelined back-to-back reads then hold.
      for (int i = 0; i < 4; i++) wr(0, AW'(i), exp3[i], 4'b1111, 1'b0);
      for (int i = 0; i < 8; i++) begin
         idle();
         if (i < 4) begin
            bank_cs[0][0] = 1'b1;
            bank_addr     = AW'(i);
         end
         tick();
         if (i == 1) chk("b2b_before", 64'(bank_rdata[0][0]), 64'h1234_5678);
         if (i >= 2) chk($sformatf("b2b_%0d", i), 64'(bank_rdata[0][0]), 64'(exp3[(i - 2 < 3) ? i - 2 : 3]));
      end

      // Independent columns accessed together.
      wr(1, 16'd0, 32'h5555_AAAA, 4'b1111, 1'b0);
      bank_cs   = 2'b11;
      bank_addr = 16'd0;
      tick();
      idle();
      tick();
      tick();
      chk("multi_col0", 64'(bank_rdata[0][0]), 64'hA000_0000);
      chk("multi_col1", 64'(bank_rdata[0][1]), 64'h5555_AAAA);

      // Address range boundaries.
      wr(0, 16'd1020, 32'hCAFE_F00D, 4'b1111, 1'b0);
      rd(0, 16'd1020);
      chk("rd_1020", 64'(bank_rdata[0][0]), 64'hCAFE_F00D);
      chk("oob_still_clear", 64'(oob_err_o), 64'd0);
      rd(0, 16'd1024);
      chk("rd_1024_zero", 64'(bank_rdata[0][0]), 64'd0);
      chk("oob_set", 64'(oob_err_o), 64'd1);
      wr(0, 16'd2000, 32'hFFFF_FFFF, 4'b1111, 1'b0);
      rd(0, 16'd976);
      chk("oob_wr_dropped", 64'(bank_rdata[0][0]), 64'd0);
      rd(0, 16'd5);
      chk("oob_wr_no_alias", 64'(bank_rdata[0][0]), 64'hDEAA_BEEF);

      // Default build: parity outputs stay zero even with injection.
      wr(0, 16'd7, 32'h0102_0304, 4'b1111, 1'b1);
      bank_cs[0][0] = 1'b1;
      bank_addr     = 16'd7;
      tick();
      idle();
      tick();
      tick();
      chk("par_rdata", 64'(bank_rdata[0][0]), 64'h0102_0304);
      chk("par_pulse", 64'(parity_err_o), 64'(exp_perr));
      chk("par_cnt", 64'(parity_err_cnt_o), 64'(exp_pcnt));
      tick();
      chk("par_pulse_one_cycle", 64'(parity_err_o), 64'd0);
      rd(0, 16'd6);
      chk("par_clean_read", 64'(parity_err_o), 64'd0);
      chk("par_cnt_hold", 64'(parity_err_cnt_o), 64'(exp_pcnt));

      // Reset with a read in flight, then reset mid-sweep.
      bank_cs[0][0] = 1'b1;
      bank_addr     = 16'd5;
      tick();
      idle();
      rst_ni = 1'b0;
      tick();
      rst_ni = 1'b1;
      tick();
      tick();
      tick();
      chk("inflight_discarded", 64'(bank_rdata[0][0]), 64'd0);
      chk("oob_cleared", 64'(oob_err_o), 64'd0);
      chk("init_done_cleared", 64'(init_done_o), 64'd0);
      repeat (297) tick();
      bank_cs[0][0] = 1'b1;
      bank_addr     = 16'd1;
      tick();
      idle();
      tick();
      tick();
      chk("early_set", 64'(early_access_o), 64'd1);
      chk("early_no_rdata", 64'(bank_rdata[0][0]), 64'd0);
      rst_ni = 1'b0;
      tick();
      chk("early_cleared", 64'(early_access_o), 64'd0);
      rst_ni = 1'b1;
      wait_init(n);
      chk("resweep_cycles", 64'(n), 64'd1024);
      rd(0, 16'd5);
      chk("resweep_zero", 64'(bank_rdata[0][0]), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
